sel23_demux: RTL and testbench
==============================

# sel23_demux

Registered 1-to-8 distributor for 24-bit words, the write-side counterpart of the 24-bit 8-to-1 selector. A single 24-bit input word is steered into one of eight held output registers, chosen either by an explicit 3-bit select or by an internal auto-advancing pointer. It sits ahead of the selector: it loads eight 24-bit values, such as six-digit BCD time or alarm words, which the selector then reads back by index.

## Interface
- WIDTH, 24, word width of the input and of each output register.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- EN  in  1  enable, active high; when 0 no register changes except via rst_n.
- in  in  WIDTH  data word to store.
- sel  in  3  destination index in manual mode; 3'b000 selects out1 … 3'b111 selects out8.
- wr  in  1  write strobe, sampled at the clk edge.
- auto  in  1  1 = destination taken from internal pointer; 0 = from sel.
- clr  in  1  synchronous clear of the bank, pointer and flags.
- out1..out8  out  WIDTH  held register contents.
- ptr  out  3  current auto pointer.
- valid  out  8  valid[i] = 1 once out(i+1) has been written since the last clear or reset.
- full  out  1  1 when all eight valid bits are 1.
- wr_ack  out  1  one-cycle pulse after each accepted write.

## Operation
- Accepted write: EN=1, wr=1, clr=0 at a rising clk edge.
- Destination idx = auto ? ptr : sel.
- On an accepted write:
  - out(idx+1) <= in.
  - valid[idx] <= 1.
  - wr_ack <= 1.
  - If auto=1, ptr <= ptr+1, modulo 8 (7 wraps to 0).
- Manual writes (auto=0) never change ptr.
- Rewriting an already-valid slot overwrites its data; the valid bit stays 1.
- All non-addressed output registers hold.
- clr=1 with EN=1: all outputs, valid and ptr go to 0, and wr_ack goes to 0. clr takes priority over wr in the same cycle.
- EN=0:
  - wr and clr are ignored.
  - All registers hold, including ptr and valid.
  - wr_ack goes to 0.
- full = &valid, combinational from the registered valid bits.
- full does not block writes. Writes after full continue to overwrite, and in auto mode wrap from slot 0.
- Switching auto mid-sequence is legal:
  - A manual write leaves ptr unchanged.
  - The next auto write uses the held ptr value.

## Timing
- Reset: when rst_n falls, all outputs clear immediately, without waiting for clk.
  - out1..out8 = 0.
  - ptr = 0.
  - valid = 8'h00.
  - wr_ack = 0.
  - full = 0.
- Release of rst_n is synchronous to clk. The first write can be accepted on the first rising edge after rst_n=1.
- Write latency is 1 cycle: data is visible on out(idx+1) right after the accepting edge.
- valid, ptr and full update on that same edge.
- wr_ack is high for exactly the cycle following the accepting edge.
- Back-to-back writes (wr held high) are accepted every cycle, and wr_ack stays high continuously.
- Reset asserted mid-sequence clears everything immediately. Partially loaded data is lost, and ptr restarts at 0.
- sel, in and auto only matter at the clk edge; changes between edges have no effect.

## Test plan
- Reset: drive rst_n=0 asynchronously with clk stopped.
  - Required: out1..out8=0, ptr=0, valid=00, full=0, wr_ack=0, all without any clk edge.
- Manual load: auto=0, EN=1; write sel=3'b101, in=24'h123456.
  - Required: out6=24'h123456 on the next cycle, valid=8'b0010_0000, wr_ack high for 1 cycle.
  - Required: all other outputs remain 0 and ptr stays 0.
- Auto fill and wrap: auto=1; write 9 consecutive words 24'h000001..24'h000009, wr held high.
  - After 8 writes: out1..out8 = 1..8, full=1, ptr=0, wr_ack high continuously.
  - After the 9th write: out1=24'h000009, ptr=1.
- EN gating: EN=0 with wr=1 and clr=1 for 3 cycles.
  - Required: no register changes and wr_ack=0.
  - Then EN=1 with wr=1: the write proceeds normally.
- Clear priority: in the same cycle assert clr=1 and wr=1, with bank full and ptr=5.
  - Required: all outputs 0, valid=00, ptr=0, full=0, wr_ack=0; the write is discarded.
- Mode switch: write auto=1 twice (ptr reaches 2), then auto=0 with sel=7, then auto=1.
  - Required: out8 is written by the manual write, ptr remains 2 through it, and the third auto write lands in out3.

Source files
------------

// File: rtl/sel23_demux.sv
// sel23_demux: registered 1-to-8 distributor for WIDTH-bit words.
// One input word is stored into one of eight held output registers. The
// destination comes from the explicit sel index or from an internal pointer
// that advances after each auto-mode write. This block loads the eight slots
// that the companion 8-to-1 selector later reads back by index.
//
// Write handshake: a write is accepted on any rising clk edge where EN=1,
// wr=1 and clr=0. There is no back-pressure: every such edge stores the word.
// wr_ack is high for exactly the one cycle after each accepting edge, so a
// wr held high produces a continuous wr_ack.
module sel23_demux #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  input  logic             wr,
  input  logic             auto,
  input  logic             clr,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [2:0]       ptr,
  output logic [7:0]       valid,
  output logic             full,
  output logic             wr_ack
);

  logic [WIDTH-1:0] bank [8];
  logic [2:0]       ptr_q;
  logic [7:0]       valid_q;
  logic             ack_q;

  logic             do_clr;
  logic             do_wr;
  logic [2:0]       idx;

  // Decode the per-edge action: clear wins over write, EN gates both.
  always_comb begin
    do_clr = EN & clr;
    do_wr  = EN & wr & ~clr;
    idx    = auto ? ptr_q : sel;
  end

  // Data bank: only the addressed slot loads, the others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (do_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (do_wr) begin
      bank[idx] <= in;
    end
  end

  // Valid flags: set per written slot, sticky until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 8'h00;
    end else if (do_clr) begin
      valid_q <= 8'h00;
    end else if (do_wr) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Auto pointer: advances (mod 8) only on auto-mode writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd0;
    end else if (do_clr) begin
      ptr_q <= 3'd0;
    end else if (do_wr && auto) begin
      ptr_q <= ptr_q + 3'd1;
    end
  end

  // Write acknowledge: one cycle high after each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= do_wr;
    end
  end

  // Drive the outputs from the held registers; full is pure decode.
  always_comb begin
    out1   = bank[0];
    out2   = bank[1];
    out3   = bank[2];
    out4   = bank[3];
    out5   = bank[4];
    out6   = bank[5];
    out7   = bank[6];
    out8   = bank[7];
    ptr    = ptr_q;
    valid  = valid_q;
    full   = &valid_q;
    wr_ack = ack_q;
  end

endmodule

// File: tb/tb_sel23_demux.sv
// Directed bench for sel23_demux: reset, manual load, auto fill with wrap,
// EN gating, clear priority, mode switching and asynchronous reset.
module tb_sel23_demux;

  localparam int W = 24;

  logic         clk;
  logic         clk_run;
  logic         rst_n;
  logic         en;
  logic [W-1:0] din;
  logic [2:0]   sel;
  logic         wr;
  logic         auto_m;
  logic         clr;
  logic [W-1:0] outs [8];
  logic [2:0]   ptr;
  logic [7:0]   valid;
  logic         full;
  logic         wr_ack;

  int tests = 0;
  int fails = 0;

  sel23_demux #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .EN     (en),
    .in     (din),
    .sel    (sel),
    .wr     (wr),
    .auto   (auto_m),
    .clr    (clr),
    .out1   (outs[0]),
    .out2   (outs[1]),
    .out3   (outs[2]),
    .out4   (outs[3]),
    .out5   (outs[4]),
    .out6   (outs[5]),
    .out7   (outs[6]),
    .out8   (outs[7]),
    .ptr    (ptr),
    .valid  (valid),
    .full   (full),
    .wr_ack (wr_ack)
  );

  // Clock/reset block: clock only toggles while clk_run is set.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_out%0d", tag, i + 1), 32'(outs[i]), 32'h0);
    check({tag, "_ptr"}, 32'(ptr), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_full"}, 32'(full), 32'h0);
    check({tag, "_wr_ack"}, 32'(wr_ack), 32'h0);
  endtask

  initial begin
    clk_run = 1'b0;
    rst_n   = 1'b1;
    en      = 1'b0;
    din     = '0;
    sel     = 3'd0;
    wr      = 1'b0;
    auto_m  = 1'b0;
    clr     = 1'b0;

    // Reset with the clock stopped.
    #3 rst_n = 1'b0;
    #2 check_all_zero("rst");
    #1 rst_n = 1'b1;
    clk_run = 1'b1;
    step();

    // Manual load into out6.
    en = 1'b1; auto_m = 1'b0; sel = 3'b101; din = 24'h123456; wr = 1'b1;
    step();
    wr = 1'b0;
    check("man_out6", 32'(outs[5]), 32'h123456);
    check("man_valid", 32'(valid), 32'h20);
    check("man_ack", 32'(wr_ack), 32'h1);
    check("man_ptr", 32'(ptr), 32'h0);
    check("man_out5", 32'(outs[4]), 32'h0);
    check("man_out1", 32'(outs[0]), 32'h0);
    check("man_full", 32'(full), 32'h0);
    step();
    check("man_ack_drop", 32'(wr_ack), 32'h0);
    check("man_hold_out6", 32'(outs[5]), 32'h123456);

    // Auto fill of 9 words with wr held high.
    auto_m = 1'b1; wr = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      din = 24'(k);
      step();
      check($sformatf("auto_ack_%0d", k), 32'(wr_ack), 32'h1);
      if (k == 8) begin
        for (int i = 0; i < 8; i++) check($sformatf("fill_out%0d", i + 1), 32'(outs[i]), 32'(i + 1));
        check("fill_full", 32'(full), 32'h1);
        check("fill_ptr", 32'(ptr), 32'h0);
        check("fill_valid", 32'(valid), 32'hff);
      end
    end
    check("wrap_out1", 32'(outs[0]), 32'h9);
    check("wrap_out2", 32'(outs[1]), 32'h2);
    check("wrap_ptr", 32'(ptr), 32'h1);
    check("wrap_full", 32'(full), 32'h1);
    wr = 1'b0;
    step();
    check("wrap_ack_drop", 32'(wr_ack), 32'h0);

    // EN gating: wr and clr ignored for 3 cycles.
    en = 1'b0; wr = 1'b1; clr = 1'b1; din = 24'h555555;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("en_ack_%0d", c), 32'(wr_ack), 32'h0);
      check($sformatf("en_ptr_%0d", c), 32'(ptr), 32'h1);
      check($sformatf("en_valid_%0d", c), 32'(valid), 32'hff);
      check($sformatf("en_out1_%0d", c), 32'(outs[0]), 32'h9);
      check($sformatf("en_out2_%0d", c), 32'(outs[1]), 32'h2);
    end
    en = 1'b1; clr = 1'b0; din = 24'hAAAAAA;
    step();
    wr = 1'b0;
    check("en_wr_out2", 32'(outs[1]), 32'hAAAAAA);
    check("en_wr_ptr", 32'(ptr), 32'h2);
    check("en_wr_ack", 32'(wr_ack), 32'h1);

    // Advance ptr to 5, then clear and write in the same cycle.
    wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 24'h30 + 24'(k);
      step();
    end
    check("pre_clr_ptr", 32'(ptr), 32'h5);
    check("pre_clr_full", 32'(full), 32'h1);
    check("pre_clr_out5", 32'(outs[4]), 32'h32);
    clr = 1'b1; din = 24'hFFFFFF;
    step();
    clr = 1'b0; wr = 1'b0;
    check_all_zero("clr");

    // Mode switch: auto, auto, manual sel=7, auto.
    auto_m = 1'b1; wr = 1'b1; din = 24'h0000A1;
    step();
    din = 24'h0000A2;
    step();
    check("ms_ptr2", 32'(ptr), 32'h2);
    check("ms_out1", 32'(outs[0]), 32'hA1);
    check("ms_out2", 32'(outs[1]), 32'hA2);
    auto_m = 1'b0; sel = 3'd7; din = 24'h0000B7;
    step();
    check("ms_out8", 32'(outs[7]), 32'hB7);
    check("ms_ptr_hold", 32'(ptr), 32'h2);
    auto_m = 1'b1; sel = 3'd0; din = 24'h0000C3;
    step();
    wr = 1'b0;
    check("ms_out3", 32'(outs[2]), 32'hC3);
    check("ms_out1_kept", 32'(outs[0]), 32'hA1);
    check("ms_ptr3", 32'(ptr), 32'h3);
    check("ms_valid", 32'(valid), 32'h87);
    check("ms_full", 32'(full), 32'h0);

    // Asynchronous reset mid-sequence, between clock edges.
    wr = 1'b1; din = 24'h0000D4;
    step();
    check("mid_ack", 32'(wr_ack), 32'h1);
    rst_n = 1'b0;
    #1 check_all_zero("arst");
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr = 1'b1; din = 24'h0000E1;
    step();
    wr = 1'b0;
    check("post_rst_out1", 32'(outs[0]), 32'hE1);
    check("post_rst_ptr", 32'(ptr), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
